toeplitz_acc: RTL and testbench
===============================

# toeplitz_acc

Consumer side of the Toeplitz column stream: multiplies an N-bit raw input block by the L×N Toeplitz matrix over GF(2) and produces one L-bit hash per block. Drives the synchronous `reset` of the STRIDE column-generator instances (INDEX = 0..STRIDE-1) and consumes their `col` outputs in lockstep. Raw data enters through a valid/ready stream and the hash leaves through a second valid/ready stream with a one-entry output register. Sits between the entropy-source deserializer and the hash output FIFO.

## Interface
- N, 256: input block length in bits (matrix columns); N % STRIDE == 0
- L, 128: hash length (matrix rows)
- STRIDE, 1: input bits and columns consumed per cycle; NB = N/STRIDE beats per block
- clk  in  1  clock
- reset_n  in  1  asynchronous, active-low reset
- cols  in  STRIDE*L  column group; lane k = cols[k*L +: L] = col of generator INDEX=k
- gen_reset  out  1  registered, active-high synchronous reset to all generator instances
- din  in  STRIDE  raw bits; din[k] multiplies lane k
- din_valid  in  1  raw beat valid
- din_ready  out  1  raw beat accepted when din_valid && din_ready
- hash  out  L  result
- hash_valid  out  1  hash register full
- hash_ready  in  1  downstream takes hash when hash_valid && hash_ready
- err  out  1  one-cycle pulse: block aborted

## Operation
- Reset values: gen_reset=1, hash=0, hash_valid=0, err=0, acc=0, ph=0, state=SYNC; din_ready=0 while in SYNC.
- Phase counter ph (0..NB-1) mirrors the generators: edge with gen_reset=1 → ph<=0; else ph<=(ph==NB-1)?0:ph+1. During a cycle with phase p, lane k carries matrix column p*STRIDE+k. ph runs in every state except SYNC.
- term = XOR over k of (din[k] ? lane k : 0), width L.
- States:
  - SYNC: gen_reset=1. The next edge goes to WAIT with gen_reset<=0.
  - WAIT: din_ready = (ph==0). On an accepted beat, acc<=term and the state goes to RUN. If NB==1, the block completes immediately (see completion).
  - RUN: din_ready=1. On an accepted beat, acc<=acc^term. If din_valid=0, the block is aborted: err pulses next cycle, acc is discarded and the state goes to WAIT. No resync is needed because the generators free-run.
  - Completion: the beat at ph==NB-1 completes the block with result = acc^term.
    - If the hash register is empty, or is emptied at the same edge (hash_valid && hash_ready), then hash<=result, hash_valid<=1, and the state goes to WAIT.
    - Otherwise acc<=result and the state goes to HOLD.
  - HOLD: din_ready=0. When the hash register is empty or being emptied, hash<=acc, hash_valid<=1, and the state goes to WAIT.
- hash_valid clears on hash_valid && hash_ready unless a new result loads at the same edge.
- A block starts only at ph==0. A source that is not ready there waits up to NB-1 cycles for the next ph==0.
- Reset asserted mid-block: everything returns to reset values immediately and no hash is produced. gen_reset stays 1 through reset and SYNC.

## Timing
- gen_reset is high during reset and for exactly one edge after reset_n releases. The first WAIT cycle has ph=0 with generator outputs at column group 0.
- A block occupies exactly NB consecutive accepted beats.
- Latency: hash_valid rises on the edge that accepts the final beat (0 extra cycles) when the output is free. From HOLD it rises on the first edge where the output register frees.
- Back-to-back blocks need no idle cycles: the final beat at ph=NB-1 is followed by WAIT at ph=0 with din_ready=1.
- err is high for exactly one cycle per abort. hash_valid is never raised for an aborted block.

## Structure
- toeplitz_pkg holds:
  - state enum {SYNC, WAIT, RUN, HOLD}
  - the NB and phase-width (clog2 NB) helper functions, shared with the generator top level
- Sub-module gf2_lane_mac: combinational AND-XOR of STRIDE lanes into an L-bit term, parameterised by L and STRIDE.
- The generator instances live in the parent, not inside this block.

## Test plan
- N=256, L=128, STRIDE=1, random seed; din one-hot at bit j=0, 37, 255 → hash equals matrix column j from a reference model; err=0.
- All-zero block → hash=0. Random blocks on STRIDE=1 and STRIDE=4 builds → hash equals the golden GF(2) product; 10 back-to-back blocks with hash_ready=1 → one hash per NB cycles, din_ready never low.
- din_valid dropped for 1 cycle at beat 100 → err pulse, no hash_valid. Next block accepted starting at the next ph==0 and hashes correctly.
- hash_ready=0 across two complete blocks → first hash held stable, second in HOLD with din_ready=0. Raise hash_ready → first taken, second appears the next cycle with no loss.
- Final beat and hash_ready=1 on the same edge → new hash loaded, hash_valid stays 1.
- reset_n low at beat 50, released → gen_reset=1 for one edge, outputs at reset values, next full block hashes correctly.

Source files
------------

// File: rtl/toeplitz_pkg.sv
// Shared types and sizing helpers for the Toeplitz hash consumer and its column generators.
package toeplitz_pkg;

    typedef enum logic [1:0] {
        SYNC = 2'd0,
        WAIT = 2'd1,
        RUN  = 2'd2,
        HOLD = 2'd3
    } state_t;

    // Beats per block: each beat consumes STRIDE input bits and STRIDE matrix columns.
    function automatic int nb_of(input int n, input int stride);
        return n / stride;
    endfunction

    // Width of a phase counter spanning 0..nb-1, never narrower than one bit.
    function automatic int ph_width(input int nb);
        return (nb > 1) ? $clog2(nb) : 1;
    endfunction

endpackage

// File: rtl/gf2_lane_mac.sv
// GF(2) multiply-accumulate across lanes: XOR of every column lane whose input bit is set.
module gf2_lane_mac #(
    parameter int L      = 128,
    parameter int STRIDE = 1
) (
    input  logic [STRIDE*L-1:0] cols,
    input  logic [STRIDE-1:0]   din,
    output logic [L-1:0]        term
);

    always_comb begin
        term = '0;
        for (int k = 0; k < STRIDE; k++) begin
            if (din[k]) begin
                term = term ^ cols[k*L +: L];
            end
        end
    end

endmodule

// File: rtl/toeplitz_acc.sv
// Toeplitz hash accumulator: consumes raw bits in lockstep with the column generators
// and emits one L-bit hash per N-bit block through a single-entry output register.
module toeplitz_acc
    import toeplitz_pkg::*;
#(
    parameter int N      = 256,
    parameter int L      = 128,
    parameter int STRIDE = 1
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic [STRIDE*L-1:0] cols,
    output logic                gen_reset,
    input  logic [STRIDE-1:0]   din,
    input  logic                din_valid,
    output logic                din_ready,
    output logic [L-1:0]        hash,
    output logic                hash_valid,
    input  logic                hash_ready,
    output logic                err
);

    localparam int NB = nb_of(N, STRIDE);
    localparam int PW = ph_width(NB);
    localparam logic [PW-1:0] PH_LAST = PW'(NB - 1);

    state_t        state;
    logic [PW-1:0] ph;
    logic [L-1:0]  acc;
    logic [L-1:0]  term;
    logic [L-1:0]  result;
    logic          accept;
    logic          last;
    logic          out_free;

    gf2_lane_mac #(
        .L      (L),
        .STRIDE (STRIDE)
    ) u_mac (
        .cols (cols),
        .din  (din),
        .term (term)
    );

    // A block may only start where the generators present column group 0.
    always_comb begin
        din_ready = (state == RUN) || ((state == WAIT) && (ph == '0));
        accept    = din_valid && din_ready;
        last      = (ph == PH_LAST);
        out_free  = !hash_valid || hash_ready;
        result    = ((state == RUN) ? acc : '0) ^ term;
    end

    // Phase tracks the generators, which restart on any edge that sees gen_reset high.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ph <= '0;
        end else if (gen_reset || last) begin
            ph <= '0;
        end else begin
            ph <= ph + PW'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= SYNC;
            gen_reset  <= 1'b1;
            acc        <= '0;
            hash       <= '0;
            hash_valid <= 1'b0;
            err        <= 1'b0;
        end else begin
            err <= 1'b0;
            if (hash_valid && hash_ready) begin
                hash_valid <= 1'b0;
            end
            unique case (state)
                SYNC: begin
                    gen_reset <= 1'b0;
                    state     <= WAIT;
                end
                WAIT, RUN: begin
                    if (accept && last) begin
                        if (out_free) begin
                            hash       <= result;
                            hash_valid <= 1'b1;
                            state      <= WAIT;
                        end else begin
                            acc   <= result;
                            state <= HOLD;
                        end
                    end else if (accept) begin
                        acc   <= result;
                        state <= RUN;
                    end else if (state == RUN) begin
                        // Source stalled mid-block: the partial sum is unusable.
                        acc   <= '0;
                        err   <= 1'b1;
                        state <= WAIT;
                    end
                end
                HOLD: begin
                    if (out_free) begin
                        hash       <= acc;
                        hash_valid <= 1'b1;
                        state      <= WAIT;
                    end
                end
                default: state <= SYNC;
            endcase
        end
    end

endmodule

// File: tb/tb_toeplitz_acc.sv
// Directed/randomized bench for toeplitz_acc with a generator model and a row-wise GF(2) reference.
module tb_toeplitz_acc;

    parameter int N      = 256;
    parameter int L      = 128;
    parameter int STRIDE = 1;
    localparam int NB       = N / STRIDE;
    localparam int ABORT_AT = (NB > 100) ? 100 : NB / 2;
    localparam int RESET_AT = (NB > 50) ? 50 : NB / 2;

    logic                clk = 1'b0;
    logic                reset_n;
    logic [STRIDE*L-1:0] cols;
    logic                gen_reset;
    logic [STRIDE-1:0]   din;
    logic                din_valid;
    logic                din_ready;
    logic [L-1:0]        hash;
    logic                hash_valid;
    logic                hash_ready;
    logic                err;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int err_cnt = 0;
    int gph = 0;
    bit rdy_ok;

    logic [N+L-2:0] v;
    logic [L-1:0]   tcol [N];

    toeplitz_acc #(.N(N), .L(L), .STRIDE(STRIDE)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .cols       (cols),
        .gen_reset  (gen_reset),
        .din        (din),
        .din_valid  (din_valid),
        .din_ready  (din_ready),
        .hash       (hash),
        .hash_valid (hash_valid),
        .hash_ready (hash_ready),
        .err        (err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) if (err) err_cnt <= err_cnt + 1;

    // Column generators: synchronous reset, free-running phase, lane k = column gph*STRIDE+k.
    always @(posedge clk) begin
        if (gen_reset) gph <= 0;
        else gph <= (gph == NB - 1) ? 0 : gph + 1;
    end

    always_comb begin
        cols = '0;
        for (int k = 0; k < STRIDE; k++) cols[k*L +: L] = tcol[gph*STRIDE + k];
    end

    // Matrix entry T[i][j] = v[i - j + N - 1]; hash bit i = parity of row i AND block.
    function automatic logic [L-1:0] ref_hash(input logic [N-1:0] blk);
        logic [L-1:0] r;
        r = '0;
        for (int i = 0; i < L; i++)
            for (int j = 0; j < N; j++)
                r[i] = r[i] ^ (blk[j] & v[i - j + N - 1]);
        return r;
    endfunction

    function automatic logic [N-1:0] rand_blk();
        logic [N-1:0] b;
        for (int j = 0; j < N; j++) b[j] = 1'($urandom_range(0, 1));
        return b;
    endfunction

    task automatic chk_vec(input string tag, input logic [L-1:0] obs, input logic [L-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_bit(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chk_int(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ph0();
        for (int i = 0; i < NB + 4 && !din_ready; i++) step();
        chk_bit("wait_ph0_ready", din_ready, 1'b1);
    endtask

    // Drives beats 0..NB-1; stops before beat stop_at with din_valid low and no edge consumed.
    task automatic send_block(input logic [N-1:0] blk, input int stop_at, input bit rdy_last);
        rdy_ok = 1'b1;
        for (int b = 0; b < NB; b++) begin
            if (b == stop_at) begin
                din_valid = 1'b0;
                din = '0;
                return;
            end
            din_valid = 1'b1;
            din = blk[b*STRIDE +: STRIDE];
            if (rdy_last && b == NB - 1) hash_ready = 1'b1;
            #1;
            if (!din_ready) rdy_ok = 1'b0;
            @(posedge clk);
            #1;
        end
        din_valid = 1'b0;
        din = '0;
    endtask

    task automatic run_blk(input logic [N-1:0] blk, input string tag);
        wait_ph0();
        send_block(blk, -1, 1'b0);
        chk_bit({tag, "_ready_held"}, rdy_ok, 1'b1);
        chk_bit({tag, "_valid"}, hash_valid, 1'b1);
        chk_vec({tag, "_hash"}, hash, ref_hash(blk));
        chk_bit({tag, "_err"}, err, 1'b0);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [N-1:0] blk, blk_a, blk_b, blk_c, blk_d;
        int t0, e0;
        int onehot [3] = '{0, 37, 255};

        reset_n = 1'b0;
        din = '0;
        din_valid = 1'b0;
        hash_ready = 1'b1;
        for (int i = 0; i < N + L - 1; i++) v[i] = 1'($urandom_range(0, 1));
        for (int j = 0; j < N; j++)
            for (int i = 0; i < L; i++) tcol[j][i] = v[i - j + N - 1];

        step(); step(); step();
        chk_bit("rst_gen_reset", gen_reset, 1'b1);
        chk_vec("rst_hash", hash, '0);
        chk_bit("rst_hash_valid", hash_valid, 1'b0);
        chk_bit("rst_err", err, 1'b0);
        chk_bit("rst_din_ready", din_ready, 1'b0);

        reset_n = 1'b1;
        #1;
        chk_bit("sync_gen_reset", gen_reset, 1'b1);
        step();
        chk_bit("first_wait_gen_reset", gen_reset, 1'b0);
        chk_bit("first_wait_ready", din_ready, 1'b1);

        foreach (onehot[n]) begin
            blk = '0;
            blk[onehot[n] % N] = 1'b1;
            run_blk(blk, $sformatf("onehot%0d", onehot[n]));
            chk_vec("onehot_is_column", hash, tcol[onehot[n] % N]);
        end

        run_blk('0, "zero");

        // Back-to-back random blocks with the output always drained.
        hash_ready = 1'b1;
        wait_ph0();
        t0 = cyc;
        e0 = err_cnt;
        for (int n = 0; n < 10; n++) begin
            blk = rand_blk();
            send_block(blk, -1, 1'b0);
            chk_bit($sformatf("b2b%0d_ready_held", n), rdy_ok, 1'b1);
            chk_bit($sformatf("b2b%0d_valid", n), hash_valid, 1'b1);
            chk_vec($sformatf("b2b%0d_hash", n), hash, ref_hash(blk));
        end
        chk_int("b2b_cycles", cyc - t0, 10 * NB);
        chk_int("b2b_no_err", err_cnt - e0, 0);

        // Abort: source stalls one cycle mid-block.
        step();
        wait_ph0();
        e0 = err_cnt;
        send_block(rand_blk(), ABORT_AT, 1'b0);
        step();
        chk_bit("abort_err", err, 1'b1);
        chk_bit("abort_no_valid", hash_valid, 1'b0);
        chk_bit("abort_not_ready", din_ready, 1'b0);
        step();
        chk_bit("abort_err_cleared", err, 1'b0);
        chk_bit("abort_still_no_valid", hash_valid, 1'b0);
        run_blk(rand_blk(), "post_abort");
        chk_int("abort_err_pulses", err_cnt - e0, 1);

        // Output blocked across two blocks: second result parks in HOLD.
        step();
        hash_ready = 1'b0;
        blk_a = rand_blk();
        blk_b = rand_blk();
        run_blk(blk_a, "hold_a");
        send_block(blk_b, -1, 1'b0);
        chk_bit("hold_b_ready_held", rdy_ok, 1'b1);
        chk_vec("hold_a_stable", hash, ref_hash(blk_a));
        chk_bit("hold_valid", hash_valid, 1'b1);
        chk_bit("hold_not_ready", din_ready, 1'b0);
        step(); step(); step();
        chk_vec("hold_a_still", hash, ref_hash(blk_a));
        chk_bit("hold_still_not_ready", din_ready, 1'b0);
        hash_ready = 1'b1;
        step();
        chk_vec("hold_b_hash", hash, ref_hash(blk_b));
        chk_bit("hold_b_valid", hash_valid, 1'b1);
        step();
        chk_bit("hold_drained", hash_valid, 1'b0);

        // Final beat coincides with the output being taken.
        hash_ready = 1'b0;
        blk_c = rand_blk();
        blk_d = rand_blk();
        run_blk(blk_c, "same_edge_c");
        send_block(blk_d, -1, 1'b1);
        chk_bit("same_edge_valid", hash_valid, 1'b1);
        chk_vec("same_edge_hash", hash, ref_hash(blk_d));
        chk_bit("same_edge_ready", din_ready, 1'b1);

        // Reset asserted in the middle of a block.
        hash_ready = 1'b1;
        step();
        wait_ph0();
        send_block(rand_blk(), RESET_AT, 1'b0);
        reset_n = 1'b0;
        #1;
        chk_bit("midrst_gen_reset", gen_reset, 1'b1);
        chk_vec("midrst_hash", hash, '0);
        chk_bit("midrst_valid", hash_valid, 1'b0);
        chk_bit("midrst_err", err, 1'b0);
        chk_bit("midrst_ready", din_ready, 1'b0);
        step(); step();
        reset_n = 1'b1;
        #1;
        chk_bit("midrst_sync_gen_reset", gen_reset, 1'b1);
        step();
        chk_bit("midrst_gen_reset_low", gen_reset, 1'b0);
        chk_bit("midrst_ready_ph0", din_ready, 1'b1);
        chk_bit("midrst_no_valid", hash_valid, 1'b0);
        run_blk(rand_blk(), "post_reset");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
